// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   S_IDLE/S_SHIFT/S_DONE : FSM state encoding
//   cnt_width()           : bit-counter width for a given operand width
package serial_sub_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // Counter must reach WIDTH-1; guard the degenerate case so the width never collapses to 0.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
//   start, a, b          : request side (driven by master)
//   busy, done, diff, bor: status/result side (driven by slave)
interface serial_subtractor_if #(parameter int WIDTH = 8);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bor;

   modport master (output start, a, b, input busy, done, diff, bor);
   modport slave  (input start, a, b, output busy, done, diff, bor);

endinterface

// File: rtl/full_sub.sv
// Combinational one-bit full subtractor from two half subtractors.
//   x, y : minuend / subtrahend bit
//   bin  : borrow in
//   d    : x ^ y ^ bin
//   bout : (~x & y) | (~(x ^ y) & bin)
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1, b1, b2;

   half_sub u_hs0 (.x(x),  .y(y),   .d(d1), .bout(b1));
   half_sub u_hs1 (.x(d1), .y(bin), .d(d),  .bout(b2));

   // The two borrows are never both set, so OR is sufficient.
   assign bout = b1 | b2;

endmodule

// File: rtl/half_sub.sv
// One-bit half subtractor.
//   x, y : minuend / subtrahend bit
//   d    : difference x ^ y
//   bout : borrow out (~x & y)
module half_sub (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bout
);

   assign d    = x ^ y;
   assign bout = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, LSB first,
// one bit per clock through a single full_sub cell.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : request, sampled only in IDLE; a/b captured on that edge
//   bus.busy   : high from the accepting edge until done drops
//   bus.done   : one-cycle pulse when diff/bor are published
//   bus.diff   : result, held until the next publish
//   bus.bor    : final borrow (a < b), held with diff
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res, diff_q;
   logic [WIDTH-1:0] res_nxt;
   logic             brw, bor_q;
   logic [CW-1:0]    cnt;
   logic             d, bout, last;
   logic             busy_c, done_c;

   full_sub u_cell (
      .x   (a_sh[0]),
      .y   (b_sh[0]),
      .bin (brw),
      .d   (d),
      .bout(bout)
   );

   assign last    = (cnt == LAST);
   assign res_nxt = {d, res[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_SHIFT;
         S_SHIFT: if (last)      state_nxt = S_DONE;
         S_DONE:                 state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode the state register only, so no input reaches them combinationally.
   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state)
         S_SHIFT: busy_c = 1'b1;
         S_DONE: begin
            busy_c = 1'b1;
            done_c = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.diff = diff_q;
   assign bus.bor  = bor_q;

   // Datapath: shift registers, counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res    <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bor_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_sh <= bus.a;
                  b_sh <= bus.b;
                  brw  <= 1'b0;
                  cnt  <= '0;
               end
            end
            S_SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               res  <= res_nxt;
               brw  <= bout;
               cnt  <= cnt + 1'b1;
               // Publish only on the final bit so partial results never show.
               if (last) begin
                  diff_q <= res_nxt;
                  bor_q  <= bout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
